// File: rtl/st7735_pkg.sv
// Shared constants for the ST7735 SPI driver: command bytes, init ROM,
// FSM state encodings and the SPI byte length.
package st7735_pkg;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_SLPOUT  = 8'h11;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  localparam int BYTE_PHASES = 16;
  localparam int INIT_LEN    = 18;

  localparam logic [2:0] ST_HW_RESET = 3'd0;
  localparam logic [2:0] ST_HW_WAIT  = 3'd1;
  localparam logic [2:0] ST_INIT     = 3'd2;
  localparam logic [2:0] ST_INIT_DLY = 3'd3;
  localparam logic [2:0] ST_PIXELS   = 3'd4;

  typedef struct packed {
    logic       dc;
    logic       dly;
    logic [7:0] data;
  } rom_entry_t;

  // Window covers the whole landscape panel so RAMWR never needs reissuing.
  function automatic rom_entry_t init_rom(input logic [4:0] idx);
    case (idx)
      5'd0:    init_rom = '{1'b0, 1'b1, CMD_SWRESET};
      5'd1:    init_rom = '{1'b0, 1'b1, CMD_SLPOUT};
      5'd2:    init_rom = '{1'b0, 1'b0, CMD_COLMOD};
      5'd3:    init_rom = '{1'b1, 1'b0, 8'h05};
      5'd4:    init_rom = '{1'b0, 1'b0, CMD_MADCTL};
      5'd5:    init_rom = '{1'b1, 1'b0, 8'h60};
      5'd6:    init_rom = '{1'b0, 1'b0, CMD_CASET};
      5'd7,
      5'd8,
      5'd9:    init_rom = '{1'b1, 1'b0, 8'h00};
      5'd10:   init_rom = '{1'b1, 1'b0, 8'h9F};
      5'd11:   init_rom = '{1'b0, 1'b0, CMD_RASET};
      5'd12,
      5'd13,
      5'd14:   init_rom = '{1'b1, 1'b0, 8'h00};
      5'd15:   init_rom = '{1'b1, 1'b0, 8'h7F};
      5'd16:   init_rom = '{1'b0, 1'b1, CMD_DISPON};
      default: init_rom = '{1'b0, 1'b0, CMD_RAMWR};
    endcase
  endfunction

endpackage

// File: rtl/st7735_lcd_spi_byte_tx.sv
// Mode-0 SPI byte shifter: 16 clk cycles per byte, MSB first, SCK = clk/2.
// A start on the final phase chains the next byte with no gap.
module spi_byte_tx
  import st7735_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       dc_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       sck_o,
  output logic       mosi_o,
  output logic       dc_o
);

  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;
  logic       busy_q, busy_d, sck_q, sck_d, mosi_q, mosi_d, dc_q, dc_d;
  logic       last;

  assign last = busy_q && (cnt_q == 4'(BYTE_PHASES - 1));

  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    busy_d = busy_q;
    sck_d  = sck_q;
    mosi_d = mosi_q;
    dc_d   = dc_q;
    if (start_i && (!busy_q || last)) begin
      busy_d = 1'b1;
      cnt_d  = 4'd0;
      sck_d  = 1'b0;
      mosi_d = byte_i[7];
      sh_d   = {byte_i[6:0], 1'b0};
      dc_d   = dc_i;
    end else if (last) begin
      busy_d = 1'b0;
      sck_d  = 1'b0;
      cnt_d  = 4'd0;
    end else if (busy_q) begin
      cnt_d = cnt_q + 4'd1;
      sck_d = ~cnt_q[0];
      // MOSI only moves when SCK falls into phase 0.
      if (cnt_q[0]) begin
        mosi_d = sh_q[7];
        sh_d   = {sh_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 4'd0;
      sh_q   <= 8'd0;
      busy_q <= 1'b0;
      sck_q  <= 1'b0;
      mosi_q <= 1'b0;
      dc_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      busy_q <= busy_d;
      sck_q  <= sck_d;
      mosi_q <= mosi_d;
      dc_q   <= dc_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = last;
  assign sck_o  = sck_q;
  assign mosi_o = mosi_q;
  assign dc_o   = dc_q;

endmodule

// File: rtl/st7735_lcd.sv
// ST7735 160x128 panel driver: hardware reset, init ROM, then an endless
// raster stream of RGB565 pixels requested from a combinational generator.
module st7735_lcd
  import st7735_pkg::*;
#(
  parameter int WIDTH        = 160,
  parameter int HEIGHT       = 128,
  parameter int DELAY_CYCLES = 1_800_000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  x,
  output logic [6:0]  y,
  input  logic [15:0] color,
  output logic        oled_cs,
  output logic        oled_clk,
  output logic        oled_mosi,
  output logic        oled_dc,
  output logic        reset
);

  localparam logic [31:0] DLY_LAST = 32'(DELAY_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] dly_q, dly_d;
  logic [4:0]  idx_q, idx_d;
  logic        cur_dly_q, cur_dly_d, half_q, half_d, cs_q, cs_d, res_n_q, res_n_d;
  logic [7:0]  x_q, x_d, px_lo_q, px_lo_d;
  logic [6:0]  y_q, y_d;
  logic        tx_start, tx_dc, tx_busy, tx_done, tx_ready, dly_end, issue_rom;
  logic [7:0]  tx_byte;
  rom_entry_t  ent;

  assign ent      = init_rom(idx_q);
  assign tx_ready = !tx_busy || tx_done;
  assign dly_end  = (dly_q == DLY_LAST);

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    idx_d     = idx_q;
    cur_dly_d = cur_dly_q;
    half_d    = half_q;
    cs_d      = cs_q;
    res_n_d   = res_n_q;
    x_d       = x_q;
    y_d       = y_q;
    px_lo_d   = px_lo_q;
    tx_start  = 1'b0;
    tx_byte   = ent.data;
    tx_dc     = ent.dc;
    issue_rom = 1'b0;
    case (state_q)
      ST_HW_RESET: begin
        dly_d = dly_q + 32'd1;
        if (dly_end) begin
          dly_d   = 32'd0;
          state_d = ST_HW_WAIT;
          res_n_d = 1'b1;
        end
      end
      ST_HW_WAIT: begin
        dly_d = dly_q + 32'd1;
        if (dly_end) begin
          dly_d     = 32'd0;
          cs_d      = 1'b0;
          issue_rom = 1'b1;
        end
      end
      ST_INIT: begin
        if (tx_done && cur_dly_q) begin
          state_d = ST_INIT_DLY;
          dly_d   = 32'd0;
        end else if (tx_ready) begin
          issue_rom = 1'b1;
        end
      end
      ST_INIT_DLY: begin
        dly_d = dly_q + 32'd1;
        if (dly_end) begin
          dly_d     = 32'd0;
          issue_rom = 1'b1;
        end
      end
      ST_PIXELS: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          tx_dc    = 1'b1;
          half_d   = ~half_q;
          if (!half_q) begin
            // Sample the pixel and request the next coordinate on the same edge.
            tx_byte = color[15:8];
            px_lo_d = color[7:0];
            if (x_q == 8'(WIDTH - 1)) begin
              x_d = 8'd0;
              y_d = (y_q == 7'(HEIGHT - 1)) ? 7'd0 : y_q + 7'd1;
            end else begin
              x_d = x_q + 8'd1;
            end
          end else begin
            tx_byte = px_lo_q;
          end
        end
      end
      default: state_d = ST_HW_RESET;
    endcase
    if (issue_rom) begin
      tx_start  = 1'b1;
      cur_dly_d = ent.dly;
      idx_d     = idx_q + 5'd1;
      state_d   = (idx_q == 5'(INIT_LEN - 1)) ? ST_PIXELS : ST_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_HW_RESET;
      dly_q     <= 32'd0;
      idx_q     <= 5'd0;
      cur_dly_q <= 1'b0;
      half_q    <= 1'b0;
      cs_q      <= 1'b1;
      res_n_q   <= 1'b0;
      x_q       <= 8'd0;
      y_q       <= 7'd0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      idx_q     <= idx_d;
      cur_dly_q <= cur_dly_d;
      half_q    <= half_d;
      cs_q      <= cs_d;
      res_n_q   <= res_n_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  always_ff @(posedge clk) begin
    px_lo_q <= px_lo_d;
  end

  spi_byte_tx u_tx (
    .clk     (clk),
    .rst     (rst),
    .start_i (tx_start),
    .byte_i  (tx_byte),
    .dc_i    (tx_dc),
    .busy_o  (tx_busy),
    .done_o  (tx_done),
    .sck_o   (oled_clk),
    .mosi_o  (oled_mosi),
    .dc_o    (oled_dc)
  );

  assign x       = x_q;
  assign y       = y_q;
  assign oled_cs = cs_q;
  assign reset   = res_n_q;

endmodule

// File: tb/tb_st7735_lcd.sv
// Directed bench for st7735_lcd: decodes the SPI stream against a scoreboard
// of init bytes and generator-derived pixel bytes.
module tb_st7735_lcd;

  localparam int D        = 4;
  localparam int W        = 160;
  localparam int H        = 4;
  localparam int INIT_N   = 18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [15:0] color;
  logic        oled_cs, oled_clk, oled_mosi, oled_dc, reset;

  always #5 clk = ~clk;

  assign color = {x[4:0], y[5:0], 5'h15};

  st7735_lcd #(.WIDTH(W), .HEIGHT(H), .DELAY_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .y         (y),
    .color     (color),
    .oled_cs   (oled_cs),
    .oled_clk  (oled_clk),
    .oled_mosi (oled_mosi),
    .oled_dc   (oled_dc),
    .reset     (reset)
  );

  // Scoreboard entries are {delay_after, dc, byte}.
  logic [9:0]  exp_q[$];
  logic [9:0]  init_tbl [INIT_N] = '{10'h201, 10'h211, 10'h03A, 10'h105, 10'h036, 10'h160,
                                     10'h02A, 10'h100, 10'h100, 10'h100, 10'h19F, 10'h02B,
                                     10'h100, 10'h100, 10'h100, 10'h17F, 10'h229, 10'h02C};
  logic [15:0] first_pix [3] = '{16'h0015, 16'h0815, 16'h1015};

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc = 0, last_rise = 0, bitcnt = 0, nbytes = 0;
  logic        prev_sck = 1'b0, prev_mosi = 1'b0, prev_flag = 1'b0, have_prev = 1'b0;
  logic        byte_dc = 1'b0, cs_armed = 1'b0, mon_en = 1'b0, rise_now = 1'b0, pix_started = 1'b0;
  logic        saw_line_wrap = 1'b0, saw_frame_wrap = 1'b0;
  logic [7:0]  sh = 8'd0, hi_byte = 8'd0;
  logic [7:0]  prev_x = 8'd0;
  logic [6:0]  prev_y = 7'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_cs", {31'd0, oled_cs}, 1);
    chk("rst_sck", {31'd0, oled_clk}, 0);
    chk("rst_mosi", {31'd0, oled_mosi}, 0);
    chk("rst_dc", {31'd0, oled_dc}, 0);
    chk("rst_res", {31'd0, reset}, 0);
    chk("rst_x", {24'd0, x}, 0);
    chk("rst_y", {25'd0, y}, 0);
  endtask

  task automatic arm_monitor();
    exp_q.delete();
    for (int i = 0; i < INIT_N; i++) exp_q.push_back(init_tbl[i]);
    bitcnt      = 0;
    nbytes      = 0;
    have_prev   = 1'b0;
    cs_armed    = 1'b0;
    pix_started = 1'b0;
    mon_en      = 1'b1;
  endtask

  task automatic step();
    logic [9:0]  e;
    logic [7:0]  sx;
    logic [6:0]  sy;
    logic [15:0] c;
    int          k;
    @(posedge clk);
    #1;
    cyc++;
    rise_now = oled_clk && !prev_sck;
    if (mon_en) begin
      if (oled_mosi !== prev_mosi) chk("mosi_while_sck_low", {31'd0, oled_clk}, 0);
      if (cs_armed) chk("cs_held_low", {31'd0, oled_cs}, 0);
      else if (!oled_cs) cs_armed = 1'b1;
      if (rise_now) begin
        if (bitcnt == 0) begin
          byte_dc = oled_dc;
          if (have_prev) chk("byte_gap", 32'(cyc - last_rise - 2), prev_flag ? D : 0);
        end else begin
          chk("dc_stable_in_byte", {31'd0, oled_dc}, {31'd0, byte_dc});
        end
        sh = {sh[6:0], oled_mosi};
        bitcnt++;
        last_rise = cyc;
        if (bitcnt == 8) begin
          bitcnt    = 0;
          have_prev = 1'b1;
          if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 32'(exp_q.size()), 1);
            prev_flag = 1'b0;
          end else begin
            e = exp_q.pop_front();
            chk("spi_byte", {23'd0, byte_dc, sh}, {23'd0, e[8:0]});
            prev_flag = e[9];
          end
          if (nbytes >= INIT_N && nbytes < INIT_N + 6) begin
            k = (nbytes - INIT_N) / 2;
            if (((nbytes - INIT_N) % 2) == 0) hi_byte = sh;
            else chk($sformatf("pixel%0d", k), {16'd0, hi_byte, sh}, {16'd0, first_pix[k]});
          end
          nbytes++;
        end
      end
      if ({x, y} != {prev_x, prev_y}) begin
        if (!pix_started) begin
          chk("first_pixel_after_init", 32'(nbytes), INIT_N);
          pix_started = 1'b1;
        end
        if (prev_x == 8'(W - 1)) begin
          sx = 8'd0;
          sy = (prev_y == 7'(H - 1)) ? 7'd0 : prev_y + 7'd1;
          if (prev_y == 7'(H - 1)) saw_frame_wrap = 1'b1;
          else saw_line_wrap = 1'b1;
        end else begin
          sx = prev_x + 8'd1;
          sy = prev_y;
        end
        chk("xy_next", {17'd0, x, y}, {17'd0, sx, sy});
        c = {prev_x[4:0], prev_y[5:0], 5'h15};
        exp_q.push_back({2'b01, c[15:8]});
        exp_q.push_back({2'b01, c[7:0]});
      end
    end
    prev_sck  = oled_clk;
    prev_mosi = oled_mosi;
    prev_x    = x;
    prev_y    = y;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    chk_reset_vals();

    rst = 1'b0;
    arm_monitor();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hw_reset_low", {31'd0, reset}, 0);
    end
    step();
    chk("hw_reset_release", {31'd0, reset}, 1);

    for (int i = 0; i < 40000 && !saw_frame_wrap; i++) step();
    chk("frame_wrap_seen", {31'd0, saw_frame_wrap}, 1);
    chk("line_wrap_seen", {31'd0, saw_line_wrap}, 1);

    for (int i = 0; i < 200 && !(rise_now && bitcnt == 3 && nbytes >= INIT_N); i++) step();
    chk("bit5_found", {31'd0, rise_now && bitcnt == 3}, 1);
    rst    = 1'b1;
    mon_en = 1'b0;
    step();
    chk_reset_vals();
    step();
    rst = 1'b0;
    arm_monitor();
    for (int i = 0; i < 3000 && nbytes < INIT_N + 6; i++) step();
    chk("replay_bytes", 32'(nbytes), INIT_N + 6);
    chk("replay_scoreboard_in_step", {31'd0, exp_q.size() <= 2}, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
